mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
Multi-cycle control unit for the next-generation MIPS core, replacing single-cycle combinational decode with a registered FSM (FETCH/DECODE/EXE/MEM/WB).
- Drives per-cycle datapath enables and handshakes with variable-latency instruction and data memories (req/ready).
- Detects memory timeouts and illegal opcodes, and counts retired instructions.
- Sits between the IR/PC/RF/ALU/DM datapath and the memories in the core top.

Parameters:
TIMEOUT, 16, max cycles a req may wait for ready before ERR; legal range 2..2^TO_W-1
TO_W, 5, width of wait counter
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
OpCode  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag
iready  in  1  instruction memory data valid
dready  in  1  data memory access complete
ireq  out  1  instruction fetch request
dreq  out  1  data memory request
IRWr  out  1  load IR
PCWr  out  1  load PC
PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target
RegW  out  1  RF write enable
RegDst  out  1  1 = rt, 0 = rd
Mem2R  out  1  1 = WD from DM, 0 = from ALU
MemR  out  1  data read
MemW  out  1  data write
Alusrc  out  1  1 = Imm32, 0 = RD2
EXTOp  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
Aluctrl  out  5  0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 SLT
state  out  3  FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, ERR=7
err  out  1  sticky error flag
instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-low.
- State, wait counter, err and instr_cnt are registered. All other outputs are combinational decodes of state, OpCode, Funct, Zero and ready inputs.
- Reset (rst=0): state=FETCH, wait counter=0, err=0, instr_cnt=0. All enables and requests forced 0 while rst=0. Reset mid-instruction aborts it immediately, with no partial writes after assertion.
- Supported instructions: R-type (op 000000) with Funct addu 100001, subu 100011, and 100100, or 100101, slt 101010; ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010.
- FETCH: ireq=1.
  - iready=1: IRWr=1, PCWr=1, PCSrc=00, go to DECODE, clear wait counter.
  - iready=0: wait counter +1.
  - Counter == TIMEOUT-1 with iready=0: go to ERR.
- DECODE:
  - j: PCWr=1, PCSrc=10, instr_cnt+1, go to FETCH.
  - Unsupported opcode, or unsupported R-type Funct: go to ERR.
  - Otherwise: go to EXE.
- EXE, per instruction:
  - R-type: Alusrc=0, Aluctrl per Funct, go to WB.
  - ori: Alusrc=1, EXTOp=00, Aluctrl=OR, go to WB.
  - lui: Alusrc=1, EXTOp=10, Aluctrl=OR, go to WB. The datapath forces RD1 to zero via rs=$0 encoding.
  - lw/sw: Alusrc=1, EXTOp=01, Aluctrl=ADDU, go to MEM.
  - beq: Alusrc=0, Aluctrl=SUBU, EXTOp=01, PCWr=Zero, PCSrc=01, instr_cnt+1, go to FETCH.
- MEM: dreq=1, MemR=1 for lw, MemW=1 for sw. MemW and dready must not both be reused: MemW is held until dready.
  - dready=1: sw goes to FETCH with instr_cnt+1; lw goes to WB. Wait counter clears.
  - Timeout rule is identical to FETCH.
- WB: RegW=1 for exactly one cycle, instr_cnt+1, go to FETCH.
  - lw: Mem2R=1, RegDst=1.
  - ori/lui: Mem2R=0, RegDst=1.
  - R-type: Mem2R=0, RegDst=0.
- ERR: all enables and requests 0, err=1. Sticky until rst=0.
- Combinational outputs in any state not listed above are 0.
- Counters: instr_cnt wraps modulo 2^CNT_W with no flag. The wait counter saturates only via the ERR transition.
- Simultaneous events: ready arriving on the timeout cycle counts as success, so ready wins. A ready input outside its req state is ignored.
- Latency with iready/dready asserted in the same cycle as the request:
  - j: 2 cycles.
  - beq: 3 cycles.
  - R/ori/lui: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.

Test Plan:
1. Reset then addu (op 0, funct 100001), iready tied 1 -> states 0,1,2,4,0; one RegW pulse with RegDst=0; instr_cnt=1 after 4 cycles.
2. lw with dready delayed 3 cycles -> MEM held 4 cycles with dreq=1, MemR=1; WB asserts Mem2R=1, RegW=1; total 8 cycles; instr_cnt=1.
3. beq with Zero=1, then with Zero=0 -> PCWr=1/PCSrc=01 in EXE for the first; PCWr=0 for the second; both return to FETCH; instr_cnt=2.
4. iready held 0 with TIMEOUT=16 -> ERR entered after 16 FETCH cycles; err=1; all enables 0; stays in ERR until rst pulse; then state=0, err=0.
5. Opcode 111111 -> DECODE goes to ERR; no RegW, PCWr or MemW ever asserted after the IRWr cycle.
6. rst asserted during MEM of sw -> MemW/dreq drop asynchronously; after release state=FETCH, instr_cnt=0.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// mips_mc_ctrl
//   Multi-cycle control unit for the MIPS core. A registered FSM steps each
//   instruction through FETCH / DECODE / EXE / MEM / WB, and handshakes with
//   variable-latency instruction and data memories through req/ready pairs.
//   If a memory never answers, or the opcode is not supported, the FSM parks
//   in a sticky ERR state. The unit also counts retired instructions.
//
//   Parameters
//     TIMEOUT  max cycles a request may wait for ready before ERR (2..2^TO_W-1)
//     TO_W     width of the wait counter
//     CNT_W    width of the retired-instruction counter
//
//   Ports
//     clk, rst          clock (rising edge), asynchronous active-low reset
//     OpCode, Funct     IR[31:26], IR[5:0]; held by the datapath after IRWr
//     Zero              ALU zero flag, used by beq
//     iready, dready    instruction / data memory ready
//     ireq, dreq        instruction / data memory request
//     IRWr, PCWr        IR load, PC load
//     PCSrc             00 PC+4, 01 branch target, 10 jump target
//     RegW, RegDst      RF write enable, 1 = rt / 0 = rd destination
//     Mem2R             1 = write data from DM, 0 = from ALU
//     MemR, MemW        data memory read / write
//     Alusrc            1 = Imm32, 0 = RD2
//     EXTOp             00 zero-ext, 01 sign-ext, 10 imm<<16
//     Aluctrl           0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 SLT
//     state             FETCH=0 DECODE=1 EXE=2 MEM=3 WB=4 ERR=7
//     err               sticky error flag
//     instr_cnt         retired instructions, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module mips_mc_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             iready,
  input  logic             dready,
  output logic             ireq,
  output logic             dreq,
  output logic             IRWr,
  output logic             PCWr,
  output logic [1:0]       PCSrc,
  output logic             RegW,
  output logic             RegDst,
  output logic             Mem2R,
  output logic             MemR,
  output logic             MemW,
  output logic             Alusrc,
  output logic [1:0]       EXTOp,
  output logic [4:0]       Aluctrl,
  output logic [2:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_AND, C_OR, C_SLT,
    C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_ILL
  } instr_e;

  localparam logic [4:0] ALU_ADDU = 5'd0;
  localparam logic [4:0] ALU_SUBU = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_SLT  = 5'd4;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HIGH = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Last wait-counter value before a still-pending request becomes a timeout.
  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(TIMEOUT - 1);

  state_e           r_state;
  logic [TO_W-1:0]  r_wait;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  instr_e           w_instr;
  logic             w_rtype;
  logic [4:0]       w_alu_r;
  logic             w_wait_expired;

  // -------------------------------------------------------------------------
  // Instruction class decode. The datapath keeps IR stable from the IRWr
  // cycle until the next fetch, so OpCode/Funct are valid in every state
  // after FETCH.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; that is what keeps combinational blocks latch-free.
    w_instr = C_ILL;
    case (OpCode)
      6'b000000: begin
        case (Funct)
          6'b100001: w_instr = C_ADDU;
          6'b100011: w_instr = C_SUBU;
          6'b100100: w_instr = C_AND;
          6'b100101: w_instr = C_OR;
          6'b101010: w_instr = C_SLT;
          default:   w_instr = C_ILL;
        endcase
      end
      6'b001101: w_instr = C_ORI;
      6'b001111: w_instr = C_LUI;
      6'b100011: w_instr = C_LW;
      6'b101011: w_instr = C_SW;
      6'b000100: w_instr = C_BEQ;
      6'b000010: w_instr = C_J;
      default:   w_instr = C_ILL;
    endcase
  end

  always_comb begin
    w_rtype = 1'b1;
    w_alu_r = ALU_ADDU;
    case (w_instr)
      C_ADDU:  w_alu_r = ALU_ADDU;
      C_SUBU:  w_alu_r = ALU_SUBU;
      C_AND:   w_alu_r = ALU_AND;
      C_OR:    w_alu_r = ALU_OR;
      C_SLT:   w_alu_r = ALU_SLT;
      default: w_rtype = 1'b0;
    endcase
  end

  assign w_wait_expired = (r_wait == WAIT_LAST);

  // -------------------------------------------------------------------------
  // State, wait counter, sticky error and retired-instruction counter.
  // A ready seen on the expiry cycle still counts as success: the ready
  // branch is tested before the timeout.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      case (r_state)
        S_FETCH: begin
          if (iready) begin
            r_state <= S_DECODE;
            r_wait  <= '0;
          end else if (w_wait_expired) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_wait  <= r_wait + TO_W'(1);
          end
        end

        S_DECODE: begin
          if (w_instr == C_J) begin
            r_state <= S_FETCH;
            r_cnt   <= r_cnt + CNT_W'(1);
          end else if (w_instr == C_ILL) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_state <= S_EXE;
          end
        end

        S_EXE: begin
          if (w_rtype || w_instr == C_ORI || w_instr == C_LUI) begin
            r_state <= S_WB;
          end else if (w_instr == C_LW || w_instr == C_SW) begin
            r_state <= S_MEM;
          end else if (w_instr == C_BEQ) begin
            r_state <= S_FETCH;
            r_cnt   <= r_cnt + CNT_W'(1);
          end else begin
            // Only reachable if IR changed under us after DECODE.
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end
        end

        S_MEM: begin
          if (dready) begin
            r_wait <= '0;
            if (w_instr == C_SW) begin
              r_state <= S_FETCH;
              r_cnt   <= r_cnt + CNT_W'(1);
            end else begin
              r_state <= S_WB;
            end
          end else if (w_wait_expired) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_wait  <= r_wait + TO_W'(1);
          end
        end

        S_WB: begin
          r_state <= S_FETCH;
          r_cnt   <= r_cnt + CNT_W'(1);
        end

        S_ERR: begin
          r_state <= S_ERR;
        end

        default: begin
          r_state <= S_ERR;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  assign state     = r_state;
  assign err       = r_err;
  assign instr_cnt = r_cnt;

  // -------------------------------------------------------------------------
  // Datapath controls: pure decode of state, IR fields, Zero and ready.
  // Gating everything with rst makes the enables drop the moment reset is
  // asserted, so an aborted instruction cannot write anything afterwards.
  // -------------------------------------------------------------------------
  always_comb begin
    ireq    = 1'b0;
    dreq    = 1'b0;
    IRWr    = 1'b0;
    PCWr    = 1'b0;
    PCSrc   = PC_SEQ;
    RegW    = 1'b0;
    RegDst  = 1'b0;
    Mem2R   = 1'b0;
    MemR    = 1'b0;
    MemW    = 1'b0;
    Alusrc  = 1'b0;
    EXTOp   = EXT_ZERO;
    Aluctrl = ALU_ADDU;

    if (rst) begin
      case (r_state)
        S_FETCH: begin
          ireq = 1'b1;
          if (iready) begin
            IRWr  = 1'b1;
            PCWr  = 1'b1;
            PCSrc = PC_SEQ;
          end
        end

        S_DECODE: begin
          if (w_instr == C_J) begin
            PCWr  = 1'b1;
            PCSrc = PC_JUMP;
          end
        end

        S_EXE: begin
          if (w_rtype) begin
            Alusrc  = 1'b0;
            Aluctrl = w_alu_r;
          end else begin
            case (w_instr)
              C_ORI: begin
                Alusrc  = 1'b1;
                EXTOp   = EXT_ZERO;
                Aluctrl = ALU_OR;
              end
              C_LUI: begin
                Alusrc  = 1'b1;
                EXTOp   = EXT_HIGH;
                Aluctrl = ALU_OR;
              end
              C_LW, C_SW: begin
                Alusrc  = 1'b1;
                EXTOp   = EXT_SIGN;
                Aluctrl = ALU_ADDU;
              end
              C_BEQ: begin
                Alusrc  = 1'b0;
                EXTOp   = EXT_SIGN;
                Aluctrl = ALU_SUBU;
                PCWr    = Zero;
                PCSrc   = PC_BRANCH;
              end
              default: ;
            endcase
          end
        end

        S_MEM: begin
          // MemW stays high every MEM cycle until dready completes the store.
          dreq = 1'b1;
          MemR = (w_instr == C_LW);
          MemW = (w_instr == C_SW);
        end

        S_WB: begin
          RegW   = 1'b1;
          RegDst = !w_rtype;
          Mem2R  = (w_instr == C_LW);
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_mc_ctrl
//   Self-checking bench for mips_mc_ctrl. Each instruction is played as a
//   list of phases (fetch wait cycles, decode, execute, memory wait cycles,
//   write-back) derived from the instruction's class, with the expected
//   controls for each phase written from the instruction table. Ready inputs
//   are asserted at random in states that do not request them.
// ---------------------------------------------------------------------------
module tb_mips_mc_ctrl;

  localparam int TMO   = 16;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic       ireq;
    logic       dreq;
    logic       irwr;
    logic       pcwr;
    logic [1:0] pcsrc;
    logic       regw;
    logic       regdst;
    logic       mem2r;
    logic       memr;
    logic       memw;
    logic       alusrc;
    logic [1:0] extop;
    logic [4:0] aluctrl;
  } outs_t;

  typedef enum int {
    K_ADDU, K_SUBU, K_AND, K_OR, K_SLT,
    K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J,
    K_BADOP, K_BADFN
  } kind_e;

  logic             clk;
  logic             rst;
  logic [5:0]       OpCode;
  logic [5:0]       Funct;
  logic             Zero;
  logic             iready;
  logic             dready;
  logic             ireq, dreq, IRWr, PCWr, RegW, RegDst, Mem2R, MemR, MemW, Alusrc;
  logic [1:0]       PCSrc, EXTOp;
  logic [4:0]       Aluctrl;
  logic [2:0]       state;
  logic             err;
  logic [CNT_W-1:0] instr_cnt;

  outs_t w_obs;
  assign w_obs = {ireq, dreq, IRWr, PCWr, PCSrc, RegW, RegDst, Mem2R,
                  MemR, MemW, Alusrc, EXTOp, Aluctrl};

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;

  mips_mc_ctrl #(.TIMEOUT(TMO), .TO_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .iready(iready), .dready(dready), .ireq(ireq), .dreq(dreq),
    .IRWr(IRWr), .PCWr(PCWr), .PCSrc(PCSrc), .RegW(RegW), .RegDst(RegDst),
    .Mem2R(Mem2R), .MemR(MemR), .MemW(MemW), .Alusrc(Alusrc),
    .EXTOp(EXTOp), .Aluctrl(Aluctrl), .state(state), .err(err),
    .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive ready inputs (called just after a rising edge),
  // compare at the falling edge, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [2:0] es, input outs_t eo,
                     input logic ir, input logic dr);
    iready = ir;
    dready = dr;
    @(negedge clk);
    check({tag, " state"}, 32'(state), 32'(es));
    check({tag, " outs"}, 32'(w_obs), 32'(eo));
    check({tag, " err"}, 32'(err), 32'(es == 3'd7));
    @(posedge clk);
    #1;
  endtask

  // Reset pulse used after ERR: everything forced low while rst=0.
  task automatic reset_pulse(input string tag);
    rst = 1'b0;
    #1;
    check({tag, " rst state"}, 32'(state), 32'd0);
    check({tag, " rst err"}, 32'(err), 32'd0);
    check({tag, " rst cnt"}, instr_cnt, 32'd0);
    check({tag, " rst outs"}, 32'(w_obs), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " rst held outs"}, 32'(w_obs), 32'd0);
    rst = 1'b1;
    m_cnt = 0;
  endtask

  task automatic err_park(input string tag);
    for (int i = 0; i < 3; i++) cyc({tag, " ERR"}, 3'd7, '0, rbit(), rbit());
    reset_pulse(tag);
  endtask

  function automatic logic [11:0] enc(input kind_e k);
    logic [5:0] bad_ops [4];
    bad_ops = '{6'b111111, 6'b001000, 6'b000001, 6'b110000};
    case (k)
      K_ADDU:  return {6'b000000, 6'b100001};
      K_SUBU:  return {6'b000000, 6'b100011};
      K_AND:   return {6'b000000, 6'b100100};
      K_OR:    return {6'b000000, 6'b100101};
      K_SLT:   return {6'b000000, 6'b101010};
      K_ORI:   return {6'b001101, 6'($urandom)};
      K_LUI:   return {6'b001111, 6'($urandom)};
      K_LW:    return {6'b100011, 6'($urandom)};
      K_SW:    return {6'b101011, 6'($urandom)};
      K_BEQ:   return {6'b000100, 6'($urandom)};
      K_J:     return {6'b000010, 6'($urandom)};
      K_BADOP: return {bad_ops[$urandom_range(0, 3)], 6'($urandom)};
      default: return {6'b000000, 6'b100000};
    endcase
  endfunction

  // Play one instruction. idly/ddly = cycles before ready; >= TMO means never.
  task automatic exec(input string tag, input kind_e k, input logic z,
                      input int idly, input int ddly);
    outs_t eo;
    logic [11:0] code;
    bit rtype;
    rtype = (k <= K_SLT);
    code = enc(k);
    OpCode = code[11:6];
    Funct  = code[5:0];
    Zero   = z;

    for (int i = 0; i < TMO; i++) begin
      eo = '0;
      eo.ireq = 1'b1;
      if (i == idly) begin
        eo.irwr = 1'b1;
        eo.pcwr = 1'b1;
      end
      cyc({tag, " FETCH"}, 3'd0, eo, i == idly, rbit());
      if (i == idly) break;
    end
    if (idly >= TMO) begin
      err_park({tag, " ifetch timeout"});
      return;
    end

    eo = '0;
    if (k == K_J) begin
      eo.pcwr  = 1'b1;
      eo.pcsrc = 2'b10;
    end
    cyc({tag, " DECODE"}, 3'd1, eo, rbit(), rbit());
    if (k == K_J) begin
      m_cnt++;
      check({tag, " cnt"}, instr_cnt, 32'(m_cnt));
      return;
    end
    if (k == K_BADOP || k == K_BADFN) begin
      err_park({tag, " illegal"});
      return;
    end

    eo = '0;
    case (k)
      K_ADDU: eo.aluctrl = 5'd0;
      K_SUBU: eo.aluctrl = 5'd1;
      K_AND:  eo.aluctrl = 5'd2;
      K_OR:   eo.aluctrl = 5'd3;
      K_SLT:  eo.aluctrl = 5'd4;
      K_ORI:  begin eo.alusrc = 1'b1; eo.extop = 2'b00; eo.aluctrl = 5'd3; end
      K_LUI:  begin eo.alusrc = 1'b1; eo.extop = 2'b10; eo.aluctrl = 5'd3; end
      K_LW, K_SW: begin eo.alusrc = 1'b1; eo.extop = 2'b01; eo.aluctrl = 5'd0; end
      K_BEQ:  begin
        eo.extop = 2'b01; eo.aluctrl = 5'd1; eo.pcwr = z; eo.pcsrc = 2'b01;
      end
      default: ;
    endcase
    cyc({tag, " EXE"}, 3'd2, eo, rbit(), rbit());
    if (k == K_BEQ) begin
      m_cnt++;
      check({tag, " cnt"}, instr_cnt, 32'(m_cnt));
      return;
    end

    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < TMO; i++) begin
        eo = '0;
        eo.dreq = 1'b1;
        eo.memr = (k == K_LW);
        eo.memw = (k == K_SW);
        cyc({tag, " MEM"}, 3'd3, eo, rbit(), i == ddly);
        if (i == ddly) break;
      end
      if (ddly >= TMO) begin
        err_park({tag, " dmem timeout"});
        return;
      end
      if (k == K_SW) begin
        m_cnt++;
        check({tag, " cnt"}, instr_cnt, 32'(m_cnt));
        return;
      end
    end

    eo = '0;
    eo.regw   = 1'b1;
    eo.regdst = !rtype;
    eo.mem2r  = (k == K_LW);
    cyc({tag, " WB"}, 3'd4, eo, rbit(), rbit());
    m_cnt++;
    check({tag, " cnt"}, instr_cnt, 32'(m_cnt));
  endtask

  initial begin
    outs_t eo;
    rst = 1'b0;
    OpCode = '0;
    Funct = '0;
    Zero = 1'b0;
    iready = 1'b1;
    dready = 1'b1;

    // Reset state, with ready inputs high: controls must stay 0.
    #2;
    check("reset state", 32'(state), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset cnt", instr_cnt, 32'd0);
    check("reset outs", 32'(w_obs), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed steps.
    exec("addu", K_ADDU, 1'b0, 0, 0);
    exec("lw d3", K_LW, 1'b0, 0, 3);
    exec("beq z1", K_BEQ, 1'b1, 0, 0);
    exec("beq z0", K_BEQ, 1'b0, 0, 0);
    exec("j", K_J, 1'b0, 0, 0);
    exec("sw", K_SW, 1'b0, 0, 0);
    exec("ori", K_ORI, 1'b0, 2, 0);
    exec("lui", K_LUI, 1'b0, 0, 0);
    exec("ifetch last", K_SLT, 1'b0, TMO - 1, 0);
    exec("dmem last", K_SW, 1'b0, 0, TMO - 1);
    exec("ifetch tmo", K_ADDU, 1'b0, TMO, 0);
    exec("bad op", K_BADOP, 1'b0, 0, 0);
    exec("bad funct", K_BADFN, 1'b0, 0, 0);
    exec("dmem tmo", K_LW, 1'b0, 1, TMO);

    // Reset during MEM of a store: MemW/dreq drop without a clock edge.
    exec("pre sw", K_AND, 1'b0, 0, 0);
    OpCode = 6'b101011;
    Funct  = 6'b000000;
    eo = '0; eo.ireq = 1'b1; eo.irwr = 1'b1; eo.pcwr = 1'b1;
    cyc("rst-sw FETCH", 3'd0, eo, 1'b1, 1'b0);
    cyc("rst-sw DECODE", 3'd1, '0, 1'b0, 1'b0);
    eo = '0; eo.alusrc = 1'b1; eo.extop = 2'b01;
    cyc("rst-sw EXE", 3'd2, eo, 1'b0, 1'b0);
    iready = 1'b0;
    dready = 1'b0;
    @(negedge clk);
    check("rst-sw MEM memw", 32'(MemW), 32'd1);
    check("rst-sw MEM dreq", 32'(dreq), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst-sw async memw", 32'(MemW), 32'd0);
    check("rst-sw async dreq", 32'(dreq), 32'd0);
    check("rst-sw async state", 32'(state), 32'd0);
    check("rst-sw async cnt", instr_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_cnt = 0;
    eo = '0; eo.ireq = 1'b1;
    cyc("rst-sw after", 3'd0, eo, 1'b0, 1'b1);
    exec("after rst", K_OR, 1'b0, 0, 0);

    // Randomised instruction stream.
    for (int n = 0; n < 60; n++) begin
      kind_e k;
      int idly, ddly, r;
      r = $urandom_range(0, 39);
      if (r < 36)      k = kind_e'(r % 11);
      else if (r < 38) k = kind_e'(K_BADOP + (r - 36));
      else             k = K_LW;
      idly = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO - 1) : 0;
      ddly = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 2);
      if ($urandom_range(0, 29) == 0) idly = TMO;
      if ($urandom_range(0, 29) == 0) ddly = TMO;
      exec($sformatf("rnd%0d", n), k, rbit(), idly, ddly);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
